// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: issues mult/div operations, holds the pipeline
// while busy, and owns the architectural HI/LO registers.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [2:0]  op_reg, op_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_b, uq, ur, quo_s, rem_s, quo_u, rem_u;
    logic        b_zero;

    // Results are formed combinationally from the latched operands and only
    // committed on the final busy edge.
    always_comb begin
        prod_u = {32'd0, a_reg} * {32'd0, b_reg};
        prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
        b_zero = (b_reg == 32'd0);
        // Substitute 1 for a zero divisor; the result is discarded anyway.
        div_b  = b_zero ? 32'd1 : b_reg;
        quo_u  = a_reg / div_b;
        rem_u  = a_reg % div_b;
        // Signed divide via magnitudes so that 0x80000000 / -1 wraps cleanly.
        abs_a  = a_reg[31] ? -a_reg : a_reg;
        abs_b  = div_b[31] ? -div_b : div_b;
        uq     = abs_a / abs_b;
        ur     = abs_a % abs_b;
        quo_s  = (a_reg[31] ^ div_b[31]) ? -uq : uq;
        rem_s  = a_reg[31] ? -ur : ur;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_next = BUSY;
                            a_next     = rs_data;
                            b_next     = rt_data;
                            op_next    = op;
                            cnt_next   = (op == OP_MULT || op == OP_MULTU) ?
                                         4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        end
                        OP_MTHI: hi_next = rs_data;
                        OP_MTLO: lo_next = rs_data;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = IDLE;
                    case (op_reg)
                        OP_MULT:  {hi_next, lo_next} = prod_s;
                        OP_MULTU: {hi_next, lo_next} = prod_u;
                        OP_DIV: begin
                            if (!b_zero) begin
                                hi_next = rem_s;
                                lo_next = quo_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!b_zero) begin
                                hi_next = rem_u;
                                lo_next = quo_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            op_reg    <= 3'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign busy  = (state_reg == BUSY);
    assign stall = d_uses_md & (busy | (start & (op >= OP_MULT) & (op <= OP_DIVU)));
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO results are queued at issue and
// popped in the first non-busy cycle after each operation.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        d_uses_md;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;
    exp_t sb_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .d_uses_md(d_uses_md),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue op at a negedge, track busy length, optionally inject an ignored
    // start at busy cycle inject, then compare against the scoreboard head.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                          input int n, input logic dmd, input int inject);
        exp_t e;
        int   cycles;
        sb_q.push_back('{tag, ehi, elo, n});
        start = 1'b1; op = o; rs_data = rs; rt_data = rt; d_uses_md = dmd;
        #1;
        if (dmd) check({tag, "_stall_start"}, {31'd0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (cycles == inject) begin
                start = 1'b1; op = 3'd4; rs_data = 32'd99; rt_data = 32'd4;
            end else begin
                start = 1'b0;
            end
            #1;
            if (dmd) check({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        e = sb_q.pop_front();
        check({e.tag, "_busy_cycles"}, cycles, e.n);
        check({e.tag, "_hi"}, hi, e.hi);
        check({e.tag, "_lo"}, lo, e.lo);
        if (dmd) check({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
        $display("[TB] %s op=%0d rs=%h rt=%h busy_cycles=%0d hi=%h lo=%h", tag, o, rs, rt, cycles, hi, lo);
        d_uses_md = 1'b0;
        @(negedge clk);
    endtask

    task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] rs,
                           input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1; op = o; rs_data = rs; rt_data = 32'h0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        $display("[TB] %s op=%0d rs=%h hi=%h lo=%h", tag, o, rs, hi, lo);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0; d_uses_md = 1'b0;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult",  3'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1'b0, 0);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0, 0);
        run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b0, 0);
        run_op("div",   3'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0, 0);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0, 0);
        run_op("divu",  3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, 0);

        move_to("mthi", 3'd5, 32'h11, 32'h11, 32'd14);
        move_to("mtlo", 3'd6, 32'h22, 32'h11, 32'h22);
        move_to("op7_ignored", 3'd7, 32'h55, 32'h11, 32'h22);
        move_to("op0_ignored", 3'd0, 32'h66, 32'h11, 32'h22);
        run_op("divu_by0", 3'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10, 1'b0, 0);

        run_op("mult_stall", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b1, 2);

        // Abort a div with a reset pulse in its third busy cycle.
        start = 1'b1; op = 3'd3; rs_data = 32'd50; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_hold_busy", {31'd0, busy}, 32'd0);
            check("abort_hold_hilo", hi | lo, 32'd0);
        end
        $display("[TB] reset_abort hi=%h lo=%h busy=%0d", hi, lo, busy);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
